mem_size_disp_capture: RTL and testbench
========================================

// Module: mem_size_disp_capture
// PURPOSE
//  Consumes the RAM-size indicator scan (digit enables ELOW_n/EMID_n/EHI_n plus the 4-bit code
//  ABIT..DBIT) and builds a stable 3-digit, 7-segment image. The indicator advances one digit per
//  RLRQ rising edge. This block samples each digit, checks scan order, and commits only complete
//  scans. It raises valid, error, change and timeout status for the front-panel driver.
// PARAMETERS
//  SETTLE_CYC     2      sysclk cycles from detected RLRQ rise to sampling of indicator outputs (1..7)
//  TIMEOUT_CYC    65535  sysclk cycles without an RLRQ rise before SCAN_VALID is dropped (16-bit)
//  SEG_ACTIVE_LOW 0      1 = invert all SEG_* outputs
// PORTS
//  sysclk     in   1  system clock
//  sys_rst_n  in   1  asynchronous active-low reset
//  RLRQ       in   1  indicator clock (same domain as sysclk); rising edge = indicator advanced
//  DISP_OFF   in   1  high = indicator outputs disabled (PD4); scan ignored
//  ABIT       in   1  digit code bit 0
//  BBIT       in   1  digit code bit 1
//  CBIT       in   1  digit code bit 2
//  DBIT       in   1  digit code bit 3
//  ELOW_n     in   1  low digit enable, active low
//  EMID_n     in   1  mid digit enable, active low
//  EHI_n      in   1  high digit enable, active low
//  SEG_LOW    out  7  low digit segments {g,f,e,d,c,b,a}
//  SEG_MID    out  7  mid digit segments
//  SEG_HI     out  7  high digit segments
//  SIZE_CODE  out  12 committed codes {hi,mid,low}, 4 bits each
//  SCAN_VALID out  1  a complete scan is committed and fresh
//  SCAN_DONE  out  1  1-cycle pulse on commit
//  SIZE_CHG   out  1  1-cycle pulse when a commit differs from the previous commit
//  SCAN_ERR   out  1  1-cycle pulse on an illegal enable pattern or order
// BEHAVIOUR
//  - Reset: SIZE_CODE=0, SCAN_VALID/SCAN_DONE/SIZE_CHG/SCAN_ERR=0, FSM=SYNC. SEG_* are blank (0).
//  - RLRQ is registered; rise = RLRQ & ~RLRQ_d. The rise loads a settle counter. Sampling occurs
//    exactly SETTLE_CYC cycles after the cycle in which the rise is detected.
//  - A rise during an active settle count restarts the count. Only one sample is taken.
//  - Enable vector E = ~{EHI_n,EMID_n,ELOW_n}. Legal only if onehot.
//  - FSM states: SYNC, GOT_LOW, GOT_MID.
//    SYNC:    E=LOW -> store low, go to GOT_LOW. E=MID or HI -> stay in SYNC, no error (resync).
//    GOT_LOW: E=MID -> store mid, go to GOT_MID. Otherwise -> SCAN_ERR, go to SYNC.
//    GOT_MID: E=HI  -> store hi, commit, go to SYNC. Otherwise -> SCAN_ERR, go to SYNC.
//    Any non-onehot E at a sample (0 or >=2 active) -> SCAN_ERR, go to SYNC, shadow discarded.
//  - Commit happens in the cycle after the HI sample. Shadow is copied to SIZE_CODE.
//    SCAN_DONE=1 and SCAN_VALID=1 in that same cycle.
//    SIZE_CHG=1 in that cycle iff the new SIZE_CODE differs from the old one and SCAN_VALID was
//    already 1 (the first commit after reset/timeout never pulses SIZE_CHG).
//  - The displayed image changes only on commit. Errors never alter SIZE_CODE or SEG_*.
//  - Timeout counter: cleared on every RLRQ rise, saturates at TIMEOUT_CYC.
//    On reaching TIMEOUT_CYC: SCAN_VALID=0, FSM=SYNC. SIZE_CODE is held.
//  - DISP_OFF=1: sampling suppressed, FSM forced to SYNC, SCAN_VALID=0, settle count cleared.
//    Timeout counter is held at 0. SIZE_CODE is held.
//  - Decode (registered from SIZE_CODE, 1 cycle after commit): codes 0-9 give standard digits.
//    Codes 10-15 give dash (g only, 7'h40). SCAN_VALID=0 blanks all SEG_* (7'h00).
//    SEG_ACTIVE_LOW inverts the final outputs, including blank.
//  - Simultaneous DISP_OFF rise and sample: DISP_OFF wins, no capture, no error.
// TESTING
//  1. Reset, then scan LOW=2, MID=0, HI=0 (RLRQ period 10):
//     -> SCAN_DONE once, SIZE_CODE=12'h002, SEG_LOW=7'h5B, SCAN_VALID=1, no SIZE_CHG.
//  2. Repeat the same scan, then LOW=6:
//     -> 2nd commit: no SIZE_CHG. 3rd commit: SIZE_CHG=1, SEG_LOW=7'h7D.
//  3. LOW then HI (MID skipped) -> SCAN_ERR pulse, SIZE_CODE unchanged.
//     Next full scan commits normally.
//  4. Both ELOW_n=0 and EMID_n=0 at a sample -> SCAN_ERR, FSM back to SYNC.
//     Starting the scan at MID -> ignored, no error.
//  5. Stop RLRQ for TIMEOUT_CYC cycles (param 100) -> SCAN_VALID falls at cycle 100, SEG_*=0.
//     Resume scan -> recommit, no SIZE_CHG.
//  6. Assert DISP_OFF mid-scan, then assert sys_rst_n=0 mid-settle:
//     -> no capture, SCAN_VALID=0, all outputs at reset values immediately (async).

Source files
------------

// File: rtl/mem_size_disp_capture.sv
// RAM-size indicator scan capture: samples the 3-digit scan, checks order,
// commits complete scans and drives registered 7-segment images.
module mem_size_disp_capture #(
  parameter int SETTLE_CYC     = 2,
  parameter int TIMEOUT_CYC    = 65535,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        RLRQ,
  input  logic        DISP_OFF,
  input  logic        ABIT,
  input  logic        BBIT,
  input  logic        CBIT,
  input  logic        DBIT,
  input  logic        ELOW_n,
  input  logic        EMID_n,
  input  logic        EHI_n,
  output logic [6:0]  SEG_LOW,
  output logic [6:0]  SEG_MID,
  output logic [6:0]  SEG_HI,
  output logic [11:0] SIZE_CODE,
  output logic        SCAN_VALID,
  output logic        SCAN_DONE,
  output logic        SIZE_CHG,
  output logic        SCAN_ERR
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    GOT_LOW = 2'd1,
    GOT_MID = 2'd2
  } state_t;

  localparam logic [2:0]  SETTLE = 3'(SETTLE_CYC);
  localparam logic [15:0] TMO    = 16'(TIMEOUT_CYC);
  localparam logic [6:0]  INV    = {7{SEG_ACTIVE_LOW}};

  function automatic logic [6:0] seg7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic        rlrq_q;
  logic [2:0]  settle_q, settle_d;
  logic [15:0] tmo_q, tmo_d;
  logic [11:0] shadow_q, shadow_d;
  logic        commit_q, commit_d;
  logic [11:0] size_q, size_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        chg_q, chg_d;
  logic        err_q, err_d;
  logic [6:0]  seg_low_q, seg_low_d;
  logic [6:0]  seg_mid_q, seg_mid_d;
  logic [6:0]  seg_hi_q, seg_hi_d;

  logic       rise;
  logic       sample;
  logic       onehot;
  logic [2:0] en;
  logic [3:0] code;

  assign rise   = RLRQ & ~rlrq_q;
  assign en     = ~{EHI_n, EMID_n, ELOW_n};
  assign code   = {DBIT, CBIT, BBIT, ABIT};
  assign onehot = $onehot(en);
  // a fresh rise restarts the settle window, so it pre-empts a due sample
  assign sample = (settle_q == 3'd1) && !rise && !DISP_OFF;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    commit_d = 1'b0;
    size_d   = size_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    chg_d    = 1'b0;
    err_d    = 1'b0;

    if (DISP_OFF) begin
      settle_d = 3'd0;
    end else if (rise) begin
      settle_d = SETTLE;
    end else if (settle_q != 3'd0) begin
      settle_d = settle_q - 3'd1;
    end else begin
      settle_d = settle_q;
    end

    if (DISP_OFF || rise) begin
      tmo_d = 16'd0;
    end else if (tmo_q != TMO) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = tmo_q;
    end

    if (sample) begin
      if (!onehot) begin
        err_d   = 1'b1;
        state_d = SYNC;
      end else begin
        case (state_q)
          SYNC: begin
            if (en[0]) begin
              shadow_d[3:0] = code;
              state_d       = GOT_LOW;
            end
          end
          GOT_LOW: begin
            if (en[1]) begin
              shadow_d[7:4] = code;
              state_d       = GOT_MID;
            end else begin
              err_d   = 1'b1;
              state_d = SYNC;
            end
          end
          GOT_MID: begin
            if (en[2]) begin
              shadow_d[11:8] = code;
              commit_d       = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = SYNC;
          end
          default: state_d = SYNC;
        endcase
      end
    end

    if (commit_q && !DISP_OFF) begin
      size_d  = shadow_q;
      done_d  = 1'b1;
      valid_d = 1'b1;
      chg_d   = valid_q && (shadow_q != size_q);
    end

    if (tmo_d == TMO) begin
      valid_d = 1'b0;
      state_d = SYNC;
    end

    if (DISP_OFF) begin
      state_d  = SYNC;
      valid_d  = 1'b0;
      commit_d = 1'b0;
    end

    seg_low_d = valid_q ? seg7(size_q[3:0])  : 7'h00;
    seg_mid_d = valid_q ? seg7(size_q[7:4])  : 7'h00;
    seg_hi_d  = valid_q ? seg7(size_q[11:8]) : 7'h00;
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= SYNC;
      rlrq_q    <= 1'b0;
      settle_q  <= 3'd0;
      tmo_q     <= 16'd0;
      shadow_q  <= 12'd0;
      commit_q  <= 1'b0;
      size_q    <= 12'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
      seg_low_q <= 7'h00;
      seg_mid_q <= 7'h00;
      seg_hi_q  <= 7'h00;
    end else begin
      state_q   <= state_d;
      rlrq_q    <= RLRQ;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      shadow_q  <= shadow_d;
      commit_q  <= commit_d;
      size_q    <= size_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
      seg_low_q <= seg_low_d;
      seg_mid_q <= seg_mid_d;
      seg_hi_q  <= seg_hi_d;
    end
  end

  assign SEG_LOW    = seg_low_q ^ INV;
  assign SEG_MID    = seg_mid_q ^ INV;
  assign SEG_HI     = seg_hi_q ^ INV;
  assign SIZE_CODE  = size_q;
  assign SCAN_VALID = valid_q;
  assign SCAN_DONE  = done_q;
  assign SIZE_CHG   = chg_q;
  assign SCAN_ERR   = err_q;

endmodule

// File: tb/tb_mem_size_disp_capture.sv
// Randomized bench for mem_size_disp_capture against a digit-level
// scan model; pulses are counted and compared after every indicator step.
module tb_mem_size_disp_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RLRQ = 1'b0;
  logic        DISP_OFF = 1'b0;
  logic        ABIT = 1'b0, BBIT = 1'b0, CBIT = 1'b0, DBIT = 1'b0;
  logic        ELOW_n = 1'b1, EMID_n = 1'b1, EHI_n = 1'b1;
  logic [6:0]  SEG_LOW, SEG_MID, SEG_HI;
  logic [11:0] SIZE_CODE;
  logic        SCAN_VALID, SCAN_DONE, SIZE_CHG, SCAN_ERR;

  always #5 clk = ~clk;

  mem_size_disp_capture #(
    .SETTLE_CYC(2),
    .TIMEOUT_CYC(100),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .sysclk(clk),
    .sys_rst_n(rst_n),
    .RLRQ(RLRQ),
    .DISP_OFF(DISP_OFF),
    .ABIT(ABIT),
    .BBIT(BBIT),
    .CBIT(CBIT),
    .DBIT(DBIT),
    .ELOW_n(ELOW_n),
    .EMID_n(EMID_n),
    .EHI_n(EHI_n),
    .SEG_LOW(SEG_LOW),
    .SEG_MID(SEG_MID),
    .SEG_HI(SEG_HI),
    .SIZE_CODE(SIZE_CODE),
    .SCAN_VALID(SCAN_VALID),
    .SCAN_DONE(SCAN_DONE),
    .SIZE_CHG(SIZE_CHG),
    .SCAN_ERR(SCAN_ERR)
  );

  int total = 0;
  int bad = 0;

  int n_done = 0, n_chg = 0, n_err = 0;
  always @(posedge clk) begin
    if (SCAN_DONE === 1'b1) n_done++;
    if (SIZE_CHG === 1'b1) n_chg++;
    if (SCAN_ERR === 1'b1) n_err++;
  end

  // reference model: expected digit position and pulse totals
  int         m_done = 0, m_chg = 0, m_err = 0;
  int         m_pos = 0;
  logic [3:0] m_sh [3];
  logic [11:0] m_size = 12'h000;
  bit         m_valid = 1'b0;

  localparam logic [6:0] DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] exp_seg(input logic [3:0] c, input bit v);
    if (!v) return 7'h00;
    if (c > 4'd9) return 7'h40;
    return DIGITS[c];
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_apply(input logic [2:0] e, input logic [3:0] c);
    logic [11:0] nc;
    if ($countones(e) != 1) begin
      m_err++;
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (e == 3'b001) begin
        m_sh[0] = c;
        m_pos = 1;
      end
    end else if (m_pos == 1) begin
      if (e == 3'b010) begin
        m_sh[1] = c;
        m_pos = 2;
      end else begin
        m_err++;
        m_pos = 0;
      end
    end else begin
      if (e == 3'b100) begin
        nc = {c, m_sh[1], m_sh[0]};
        if (m_valid && nc != m_size) m_chg++;
        m_size = nc;
        m_valid = 1'b1;
        m_done++;
      end else begin
        m_err++;
      end
      m_pos = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"}, n_done, m_done);
    check({tag, ".err"}, n_err, m_err);
    check({tag, ".chg"}, n_chg, m_chg);
    check({tag, ".size"}, SIZE_CODE, m_size);
    check({tag, ".valid"}, SCAN_VALID, m_valid);
    check({tag, ".seg_lo"}, SEG_LOW, exp_seg(m_size[3:0], m_valid));
    check({tag, ".seg_mi"}, SEG_MID, exp_seg(m_size[7:4], m_valid));
    check({tag, ".seg_hi"}, SEG_HI, exp_seg(m_size[11:8], m_valid));
  endtask

  // one indicator advance: RLRQ period 10, inputs stable over the settle
  task automatic step(input logic [2:0] e, input logic [3:0] c);
    @(negedge clk);
    {EHI_n, EMID_n, ELOW_n} = ~e;
    {DBIT, CBIT, BBIT, ABIT} = c;
    RLRQ = 1'b1;
    repeat (5) @(negedge clk);
    RLRQ = 1'b0;
    repeat (5) @(negedge clk);
    if (!DISP_OFF) model_apply(e, c);
  endtask

  task automatic scan(input logic [3:0] lo, input logic [3:0] mi,
                      input logic [3:0] hi, input string tag);
    step(3'b001, lo);
    step(3'b010, mi);
    step(3'b100, hi);
    check_all(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    scan(4'd2, 4'd0, 4'd0, "t1");
    check("t1.seg_lo_5b", SEG_LOW, 7'h5B);
    scan(4'd2, 4'd0, 4'd0, "t2a");
    scan(4'd6, 4'd0, 4'd0, "t2b");
    check("t2.seg_lo_7d", SEG_LOW, 7'h7D);

    step(3'b001, 4'd3);
    step(3'b100, 4'd3);
    check_all("t3.skip");
    scan(4'd1, 4'd2, 4'd3, "t3.next");

    step(3'b001, 4'd5);
    step(3'b011, 4'd5);
    check_all("t4.dual");
    step(3'b000, 4'd5);
    check_all("t4.none");
    step(3'b010, 4'd7);
    check_all("t4.midstart");
    scan(4'd9, 4'd12, 4'd15, "t4.next");

    repeat (80) @(negedge clk);
    check("t5.valid_hold", SCAN_VALID, 1'b1);
    repeat (20) @(negedge clk);
    m_valid = 1'b0;
    m_pos = 0;
    check_all("t5.timeout");
    scan(4'd4, 4'd4, 4'd4, "t5.resume");

    step(3'b001, 4'd8);
    DISP_OFF = 1'b1;
    step(3'b010, 4'd8);
    m_valid = 1'b0;
    m_pos = 0;
    check_all("t6.dispoff");
    DISP_OFF = 1'b0;
    repeat (2) @(negedge clk);
    scan(4'd4, 4'd4, 4'd4, "t6.recover");

    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 3; d++) begin
        logic [2:0] e;
        logic [3:0] c;
        e = 3'(1 << d);
        if ($urandom_range(0, 5) == 0) e = 3'($urandom_range(0, 7));
        c = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'd1;
        step(e, c);
        check_all("rand");
      end
    end

    scan(4'd7, 4'd1, 4'd3, "t6.pre");
    @(negedge clk);
    {EHI_n, EMID_n, ELOW_n} = 3'b110;
    RLRQ = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_size = 12'h000;
    m_valid = 1'b0;
    m_pos = 0;
    check_all("t6.async_rst");
    @(negedge clk);
    RLRQ = 1'b0;
    repeat (5) @(negedge clk);
    check_all("t6.in_rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all("t6.after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
